mem_arbiter_n: RTL and testbench

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

---
 rtl/mem_arbiter_n.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: arbitrates N byte-serial read channels and an in-order write
// buffer onto a single byte-wide RAM port.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; when low all state holds and ram_wr=0
//   rd_req/addr/size/sign  per-channel level read requests (size 1, 2 or 4)
//   rd_done, rd_data    one-hot completion pulse and the assembled read word
//   wr_req/addr/size/data, wr_ack   store request, accepted when wr_ack=1
//   wb_empty            write buffer holds no entries
//   flush               aborts an in-flight read (never touches stores)
//   uart_full           stalls byte writes to the IO region (addr[17:16]=11)
//   ram_wr/addr/dout/din   RAM port; ram_din is valid one cycle after ram_addr
module mem_arbiter_n #(
  parameter int NUM_RD    = 2,
  parameter int WB_DEPTH  = 8,
  parameter int UART_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic [NUM_RD-1:0]     rd_req,
  input  logic [32*NUM_RD-1:0]  rd_addr,
  input  logic [3*NUM_RD-1:0]   rd_size,
  input  logic [NUM_RD-1:0]     rd_sign,
  output logic [NUM_RD-1:0]     rd_done,
  output logic [31:0]           rd_data,
  input  logic                  wr_req,
  input  logic [31:0]           wr_addr,
  input  logic [2:0]            wr_size,
  input  logic [31:0]           wr_data,
  output logic                  wr_ack,
  output logic                  wb_empty,
  input  logic                  flush,
  input  logic                  uart_full,
  output logic                  ram_wr,
  output logic [31:0]           ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);
  localparam int CH_W   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int PTR_W  = $clog2(WB_DEPTH);
  localparam int WAIT_W = (UART_WAIT > 1) ? $clog2(UART_WAIT) : 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, UART_HOLD} state_t;
  state_t state_q, state_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]  head_q, tail_q, count;
  logic [31:0]     wb_addr [WB_DEPTH];
  logic [2:0]      wb_size [WB_DEPTH];
  logic [31:0]     wb_data [WB_DEPTH];

  logic [2:0]        byte_q;     // byte index shared by READ and WRITE
  logic [CH_W-1:0]   ch_q;       // channel currently being read
  logic [CH_W-1:0]   rr_q;       // first channel searched on the next grant
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       data_q, asm_data, wr_shift;
  logic [NUM_RD-1:0] rd_done_q;
  logic [31:0]       rd_data_q;
  logic              active_q;   // low until the first clock after reset

  logic              full, enq, gnt_valid, start_rd;
  logic [CH_W-1:0]   gnt_ch;
  logic [NUM_RD-1:0] req_eff;
  logic [31:0]       cur_addr, h_addr, h_data, wr_byte_addr;
  logic [2:0]        cur_size, h_size;
  logic              cur_sign, h_last, rd_last, is_io, io_stall;
  logic              byte_issue, retire, remain_after;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] size,
                                         input logic sign);
    case (size)
      3'd1:    extend = {{24{sign & v[7]}}, v[7:0]};
      3'd2:    extend = {{16{sign & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Buffer status and store acceptance; rdy gates acceptance because a
  // frozen cycle cannot enqueue.
  assign count    = tail_q - head_q;
  assign full     = (count == (PTR_W+1)'(WB_DEPTH));
  assign wb_empty = (head_q == tail_q);
  assign enq      = wr_req & ~full & rdy & active_q;
  assign wr_ack   = enq;
  assign rd_done  = rd_done_q;
  assign rd_data  = rd_data_q;

  // A channel whose done pulse is showing still holds rd_req this cycle;
  // masking it prevents a spurious second grant.
  assign req_eff = rd_req & ~rd_done_q;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    // Walk from the farthest offset back so the nearest requester wins.
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_RD) idx = idx - NUM_RD;
      if (req_eff[idx]) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  assign cur_addr     = rd_addr[32*ch_q +: 32];
  assign cur_size     = rd_size[3*ch_q +: 3];
  assign cur_sign     = rd_sign[ch_q];
  assign h_addr       = wb_addr[head_q[PTR_W-1:0]];
  assign h_size       = wb_size[head_q[PTR_W-1:0]];
  assign h_data       = wb_data[head_q[PTR_W-1:0]];
  assign wr_byte_addr = h_addr + 32'(byte_q);
  assign wr_shift     = h_data >> {byte_q[1:0], 3'b000};
  assign is_io        = (wr_byte_addr[17:16] == 2'b11);
  assign io_stall     = is_io & uart_full;
  assign h_last       = (byte_q == h_size - 3'd1);
  assign rd_last      = (byte_q == cur_size);
  assign byte_issue   = (state_q == WRITE) & ~io_stall;
  assign retire       = byte_issue & h_last;
  assign remain_after = (tail_q != head_q + PTR_ONE) | enq;
  assign start_rd     = (state_q == IDLE) & wb_empty & gnt_valid & ~flush;

  // Byte k of a read arrives one cycle after its address, i.e. while byte_q=k+1.
  always_comb begin
    asm_data = data_q;
    if (byte_q != 3'd0)
      asm_data = data_q | (32'(ram_din) << {byte_q - 3'd1, 3'b000});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!wb_empty)     state_d = WRITE;  // older stores always go first
        else if (start_rd) state_d = READ;
      end
      READ: begin
        if (flush || rd_last) state_d = IDLE;
      end
      WRITE: begin
        if (byte_issue) begin
          if (is_io && UART_WAIT > 0) state_d = UART_HOLD;
          else if (h_last)            state_d = remain_after ? WRITE : IDLE;
        end
      end
      UART_HOLD: begin
        if (wait_q == '0) state_d = wb_empty ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_dout = '0;
    case (state_q)
      READ: if (!rd_last) ram_addr = cur_addr + 32'(byte_q);
      WRITE: begin
        if (!io_stall) begin
          ram_wr   = rdy;
          ram_addr = wr_byte_addr;
          ram_dout = wr_shift[7:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      byte_q    <= '0;
      ch_q      <= '0;
      rr_q      <= '0;
      wait_q    <= '0;
      data_q    <= '0;
      rd_done_q <= '0;
      rd_data_q <= '0;
      active_q  <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (rdy) begin
        rd_done_q <= '0;
        if (enq)    tail_q <= tail_q + PTR_ONE;
        if (retire) head_q <= head_q + PTR_ONE;
        case (state_q)
          IDLE: begin
            byte_q <= '0;
            if (start_rd) begin
              ch_q   <= gnt_ch;
              data_q <= '0;
            end
          end
          READ: begin
            data_q <= asm_data;
            byte_q <= (flush || rd_last) ? 3'd0 : byte_q + 3'd1;
            if (rd_last && !flush) begin
              rd_done_q <= NUM_RD'(1) << ch_q;
              rd_data_q <= extend(asm_data, cur_size, cur_sign);
              // The pointer moves only on completion, so an aborted read
              // leaves arbitration exactly where it was.
              rr_q <= (int'(ch_q) == NUM_RD - 1) ? '0 : ch_q + CH_W'(1);
            end
          end
          WRITE: begin
            if (byte_issue) begin
              byte_q <= h_last ? 3'd0 : byte_q + 3'd1;
              if (is_io) wait_q <= WAIT_W'(UART_WAIT - 1);
            end
          end
          UART_HOLD: begin
            if (wait_q != '0) wait_q <= wait_q - WAIT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: buffer storage has no reset; clearing head/tail already discards
  // every entry and the array never feeds logic while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr[tail_q[PTR_W-1:0]] <= wr_addr;
      wb_size[tail_q[PTR_W-1:0]] <= wr_size;
      wb_data[tail_q[PTR_W-1:0]] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n with default parameters (2 channels,
// 8-entry buffer, 2 UART hold cycles) and a byte-wide RAM model.
module tb_mem_arbiter_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [1:0]  rd_req = '0;
  logic [63:0] rd_addr = '0;
  logic [5:0]  rd_size = '0;
  logic [1:0]  rd_sign = '0;
  logic [1:0]  rd_done;
  logic [31:0] rd_data;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [2:0]  wr_size = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack, wb_empty;
  logic        flush = 1'b0;
  logic        uart_full = 1'b0;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic [7:0]  mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n;
  logic [1:0]  acc;
  logic [7:0]  st_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  mem_arbiter_n dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_sign(rd_sign),
    .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
    .wr_ack(wr_ack), .wb_empty(wb_empty), .flush(flush), .uart_full(uart_full),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // RAM: read data one cycle after the address, read-before-write.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[32'h100] = 8'h11;
      mem[32'h101] = 8'h22;
      mem[32'h102] = 8'h33;
      mem[32'h103] = 8'h84;
      mem[32'h180] = 8'h80;
    end
    ram_din <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    if (ram_wr) mem[ram_addr] = ram_dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input int ch, input logic [31:0] a, input logic [2:0] s, input logic sg);
    rd_addr[32*ch +: 32] = a;
    rd_size[3*ch +: 3]   = s;
    rd_sign[ch]          = sg;
  endtask

  // Waits (bounded) for any done pulse, then checks which channel it was.
  task automatic wait_done(input logic [1:0] exp, input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rd_done == 2'b00 && k < 30);
    check({tag, "_done"}, 32'(rd_done), 32'(exp));
  endtask

  function automatic logic [7:0] peek(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, with a store request pending to show wr_ack is held low.
    wr_req  = 1'b1;
    wr_size = 3'd1;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(rd_done), 32'h0);
    check("rst_data", rd_data, 32'h0);
    check("rst_ack", 32'(wr_ack), 32'h0);
    check("rst_empty", 32'(wb_empty), 32'h1);
    check("rst_ram_wr", 32'(ram_wr), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_dout", 32'(ram_dout), 32'h0);
    rst_n = 1'b1;
    #1 check("rst_ack_hold", 32'(wr_ack), 32'h0);
    wr_req = 1'b0;

    // Word read on ch0: addresses G..G+3, done at G+5.
    @(negedge clk);
    set_rd(0, 32'h100, 3'd4, 1'b0);
    rd_req = 2'b01;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("word_addr", ram_addr, 32'h100 + 32'(k));
      @(negedge clk);
    end
    check("word_early", 32'(rd_done), 32'h0);
    @(negedge clk);
    check("word_done", 32'(rd_done), 32'h1);
    check("word_data", rd_data, 32'h84332211);
    rd_req = 2'b00;
    @(negedge clk);
    check("word_pulse", 32'(rd_done), 32'h0);

    // Signed halfword on ch0 from bytes 0x33, 0x84.
    set_rd(0, 32'h102, 3'd2, 1'b1);
    rd_req = 2'b01;
    wait_done(2'b01, "half");
    check("half_data", rd_data, 32'hFFFF8433);
    rd_req = 2'b00;

    // Byte 0x80 on ch1, signed then unsigned.
    @(negedge clk);
    set_rd(1, 32'h180, 3'd1, 1'b1);
    rd_req = 2'b10;
    wait_done(2'b10, "sbyte");
    check("sbyte_data", rd_data, 32'hFFFFFF80);
    rd_req = 2'b00;
    @(negedge clk);
    set_rd(1, 32'h180, 3'd1, 1'b0);
    rd_req = 2'b10;
    wait_done(2'b10, "ubyte");
    check("ubyte_data", rd_data, 32'h00000080);
    rd_req = 2'b00;

    // Round robin with both channels held: ch0, ch1, ch0, ch1.
    @(negedge clk);
    set_rd(0, 32'h100, 3'd1, 1'b0);
    set_rd(1, 32'h180, 3'd1, 1'b0);
    rd_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done((i % 2 == 0) ? 2'b01 : 2'b10, "rr");
      check("rr_data", rd_data, (i % 2 == 0) ? 32'h11 : 32'h80);
    end
    rd_req = 2'b00;

    // Store then load of the same word: the four store bytes come first.
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 32'h200;
    wr_size = 3'd4;
    wr_data = 32'hDEADBEEF;
    #1 check("order_ack", 32'(wr_ack), 32'h1);
    @(negedge clk);
    wr_req = 1'b0;
    set_rd(0, 32'h200, 3'd4, 1'b0);
    rd_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("order_wr", 32'(ram_wr), 32'h1);
      check("order_addr", ram_addr, 32'h200 + 32'(i));
      check("order_byte", 32'(ram_dout), 32'(st_bytes[i]));
    end
    wait_done(2'b01, "order");
    check("order_data", rd_data, 32'hDEADBEEF);
    rd_req = 2'b00;
    check("order_empty", 32'(wb_empty), 32'h1);

    // Buffer full: an IO head store stalls on uart_full, 9th store refused.
    @(negedge clk);
    uart_full = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wr_req  = 1'b1;
      wr_addr = (k == 1) ? 32'h30000 : 32'h300 + 32'(k - 1);
      wr_size = 3'd1;
      wr_data = (k == 1) ? 32'h41 : 32'(k);
      #1 check("full_ack", 32'(wr_ack), 32'(k <= 8));
      @(negedge clk);
    end
    wr_req = 1'b0;
    check("full_empty", 32'(wb_empty), 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("io_stall_wr", 32'(ram_wr), 32'h0);
      check("io_stall_addr", ram_addr, 32'h0);
    end
    uart_full = 1'b0;
    #1;
    check("io_wr", 32'(ram_wr), 32'h1);
    check("io_addr", ram_addr, 32'h30000);
    check("io_byte", 32'(ram_dout), 32'h41);
    @(negedge clk);
    check("hold1_wr", 32'(ram_wr), 32'h0);
    @(negedge clk);
    check("hold2_wr", 32'(ram_wr), 32'h0);
    @(negedge clk);
    check("after_hold_wr", 32'(ram_wr), 32'h1);
    check("after_hold_addr", ram_addr, 32'h301);
    check("after_hold_byte", 32'(ram_dout), 32'h02);
    n = 0;
    while (!wb_empty && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(wb_empty), 32'h1);
    check("drain_last", 32'(peek(32'h307)), 32'h08);
    check("drain_io", 32'(peek(32'h30000)), 32'h41);

    // Flush at G+2 of a ch1 word read.
    @(negedge clk);
    set_rd(1, 32'h100, 3'd4, 1'b0);
    rd_req = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ram_addr != 32'h100 && n < 10);
    check("flush_grant", ram_addr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    flush  = 1'b1;
    rd_req = 2'b00;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", ram_addr, 32'h0);
    acc = rd_done;
    repeat (5) begin
      @(negedge clk);
      acc |= rd_done;
    end
    check("flush_nodone", 32'(acc), 32'h0);
    // The aborted grant must not have moved the pointer: ch1 is still next.
    set_rd(0, 32'h100, 3'd1, 1'b0);
    set_rd(1, 32'h180, 3'd1, 1'b0);
    rd_req = 2'b11;
    wait_done(2'b10, "flush_rr");
    check("flush_rr_data", rd_data, 32'h80);
    rd_req = 2'b00;

    // rdy freeze mid-write, then reset mid-write.
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = 32'h400;
    wr_size = 3'd4;
    wr_data = 32'h12345678;
    #1 check("rw_ack", 32'(wr_ack), 32'h1);
    @(negedge clk);
    wr_req = 1'b0;
    n = 0;
    while (!ram_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rw_addr0", ram_addr, 32'h400);
    check("rw_byte0", 32'(ram_dout), 32'h78);
    rdy = 1'b0;
    #1 check("stall_wr", 32'(ram_wr), 32'h0);
    @(negedge clk);
    check("stall_addr", ram_addr, 32'h400);
    rdy = 1'b1;
    #1 check("resume_wr", 32'(ram_wr), 32'h1);
    @(negedge clk);
    check("resume_addr", ram_addr, 32'h401);
    check("resume_byte", 32'(ram_dout), 32'h56);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr", 32'(ram_wr), 32'h0);
    check("mid_rst_empty", 32'(wb_empty), 32'h1);
    check("mid_rst_addr", ram_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_empty", 32'(wb_empty), 32'h1);
    check("post_rst_wr", 32'(ram_wr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
